pkt_framer_tx: RTL

//  Transmit-side framer for the valid/ready/sop/eop packet stream used by the packet FIFOs.

---
 rtl/pkt_framer_tx.sv | 80 ++++++++
 1 files changed

// File: rtl/pkt_framer_tx.sv
// pkt_framer_tx: frames a raw beat stream into sop/eop packets from length descriptors,
// with one registered output stage that holds steady under backpressure.
module pkt_framer_tx #(
    parameter int DATA_WIDTH = 20,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic                  raw_valid,
    output logic                  raw_ready,
    input  logic [DATA_WIDTH-1:0] raw_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_empty,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [15:0]           err_zero_len
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic                 first_q;
    logic                 load_en, raw_fire, desc_fire, last;

    assign load_en    = !out_valid || out_ready;
    assign desc_ready = state_q == IDLE;
    assign raw_ready  = state_q == SEND && load_en;
    assign raw_fire   = raw_valid && raw_ready;
    assign desc_fire  = desc_valid && desc_ready;
    assign last       = remaining_q == LEN_WIDTH'(1);
    assign out_empty  = state_q == IDLE && !out_valid;

    // raw_fire only happens in SEND and desc_fire only in IDLE, so they never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            first_q      <= 1'b0;
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_data     <= '0;
            pkt_cnt      <= '0;
            err_zero_len <= '0;
        end else begin
            if (raw_fire) begin
                out_data    <= raw_data;
                out_valid   <= 1'b1;
                out_sop     <= first_q;
                out_eop     <= last;
                remaining_q <= remaining_q - LEN_WIDTH'(1);
                first_q     <= 1'b0;
                if (last) begin
                    pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                    state_q <= IDLE;
                end
            end else if (load_en) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
            end
            if (desc_fire) begin
                if (desc_len == '0) begin
                    if (err_zero_len != 16'hFFFF) err_zero_len <= err_zero_len + 16'd1;
                end else begin
                    remaining_q <= desc_len;
                    first_q     <= 1'b1;
                    state_q     <= SEND;
                end
            end
        end
    end
endmodule
